// File: rtl/lc_line_responder.sv
// Cache-line backing responder: serves L1D line fills and writebacks from a small line store.
// Latency: response valid exactly LATENCY cycles after request accept; one idle cycle after each handshake.
// Backpressure: single outstanding request; response held stable until hc_ready_in; requests ignored while busy.
// Optional build macro: LC_RESPONDER_STATS_EN adds saturating read/write completion counters.
module lc_line_responder #(
    parameter int B          = 64,
    parameter int PADDR_BITS = 19,
    parameter int LINES      = 64,
    parameter int LATENCY    = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  hc_valid_in,
    input  logic [PADDR_BITS-1:0] hc_addr_in,
    input  logic                  hc_we_in,
    input  logic [8*B-1:0]        hc_line_in,
    input  logic                  hc_ready_in,
    output logic                  hc_ready_out,
    output logic                  hc_valid_out,
    output logic [PADDR_BITS-1:0] hc_addr_out,
    output logic [8*B-1:0]        hc_line_out
`ifdef LC_RESPONDER_STATS_EN
    ,
    output logic [15:0]           rd_count_out,
    output logic [15:0]           wr_count_out
`endif
);

    localparam int OFF_W = $clog2(B);
    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [PADDR_BITS-1:0] ALIGN_MASK = ~PADDR_BITS'(B - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [PADDR_BITS-1:0] addr_q;
    logic                  we_q;
    logic [8*B-1:0]        line_q;
    logic [LINES-1:0]      written;
    logic [8*B-1:0]        mem [LINES];
    logic [IDX_W-1:0]      idx;
    logic                  commit;

    assign idx    = addr_q[OFF_W +: IDX_W];
    assign commit = (state == WAIT) && (cnt == '0);

    // Request/response FSM with registered handshake outputs and line visibility bits.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            line_q       <= '0;
            written      <= '0;
            hc_ready_out <= 1'b0;
            hc_valid_out <= 1'b0;
            hc_addr_out  <= '0;
            hc_line_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hc_ready_out && hc_valid_in) begin
                        addr_q       <= hc_addr_in & ALIGN_MASK;
                        we_q         <= hc_we_in;
                        line_q       <= hc_line_in;
                        cnt          <= CNT_W'(LATENCY - 1);
                        hc_ready_out <= 1'b0;
                        state        <= WAIT;
                    end else begin
                        // Ready comes up one cycle after entering IDLE, giving the handoff gap.
                        hc_ready_out <= 1'b1;
                    end
                end
                WAIT: begin
                    if (commit) begin
                        state        <= RESP;
                        hc_valid_out <= 1'b1;
                        hc_addr_out  <= addr_q;
                        if (we_q) begin
                            written[idx] <= 1'b1;
                            hc_line_out  <= line_q;
                        end else begin
                            hc_line_out  <= written[idx] ? mem[idx] : '0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (hc_ready_in) begin
                        hc_valid_out <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line store is deliberately unreset; the written bits alone gate visibility.
    always_ff @(posedge clk_in) begin
        if (commit && we_q) begin
            mem[idx] <= line_q;
        end
    end

`ifdef LC_RESPONDER_STATS_EN
    // Saturating completion counters, bumped on each response handshake.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_count_out <= '0;
            wr_count_out <= '0;
        end else if (state == RESP && hc_ready_in) begin
            if (we_q) begin
                if (wr_count_out != 16'hFFFF) wr_count_out <= wr_count_out + 16'd1;
            end else begin
                if (rd_count_out != 16'hFFFF) rd_count_out <= rd_count_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lc_line_responder.sv
// Scoreboard bench for lc_line_responder: expected responses queued at accept, compared on response.
// Latency: checks first-valid exactly LATENCY cycles after accept and the one-cycle idle handoff.
// Backpressure: exercises RESP stalls, ignored requests while busy, and reset mid-request.
module tb_lc_line_responder;

    localparam int B          = 64;
    localparam int PADDR_BITS = 19;
    localparam int LINES      = 64;
    localparam int LATENCY    = 4;
    localparam int LW         = 8 * B;
    localparam int OFF_W      = $clog2(B);
    localparam logic [PADDR_BITS-1:0] ALIGN = ~PADDR_BITS'(B - 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  hc_valid_in = 1'b0;
    logic [PADDR_BITS-1:0] hc_addr_in = '0;
    logic                  hc_we_in = 1'b0;
    logic [LW-1:0]         hc_line_in = '0;
    logic                  hc_ready_in = 1'b0;
    logic                  hc_ready_out;
    logic                  hc_valid_out;
    logic [PADDR_BITS-1:0] hc_addr_out;
    logic [LW-1:0]         hc_line_out;
`ifdef LC_RESPONDER_STATS_EN
    logic [15:0]           rd_count_out;
    logic [15:0]           wr_count_out;
`endif

    lc_line_responder #(
        .B(B), .PADDR_BITS(PADDR_BITS), .LINES(LINES), .LATENCY(LATENCY)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .hc_valid_in (hc_valid_in),
        .hc_addr_in  (hc_addr_in),
        .hc_we_in    (hc_we_in),
        .hc_line_in  (hc_line_in),
        .hc_ready_in (hc_ready_in),
        .hc_ready_out(hc_ready_out),
        .hc_valid_out(hc_valid_out),
        .hc_addr_out (hc_addr_out),
        .hc_line_out (hc_line_out)
`ifdef LC_RESPONDER_STATS_EN
        ,
        .rd_count_out(rd_count_out),
        .wr_count_out(wr_count_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PADDR_BITS-1:0] addr;
        logic [LW-1:0]         line;
    } exp_t;

    exp_t          sb[$];
    logic [LW-1:0] m_mem [LINES];
    bit            m_wr  [LINES];
    int            m_rd_cnt = 0;
    int            m_wr_cnt = 0;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int idx_of(input logic [PADDR_BITS-1:0] a);
        return int'((a >> OFF_W) % LINES);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int w = 0; w < LW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic accept(input logic we, input logic [PADDR_BITS-1:0] a,
                          input logic [LW-1:0] d, output bit ok);
        int g = 0;
        while (hc_ready_out !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        ok = (hc_ready_out === 1'b1);
        if (!ok) begin
            check("accept_timeout", 0, 1);
            return;
        end
        hc_valid_in = 1'b1;
        hc_we_in    = we;
        hc_addr_in  = a;
        hc_line_in  = d;
        @(posedge clk);
        @(negedge clk);
        hc_valid_in = 1'b0;
        hc_we_in    = 1'b0;
        hc_line_in  = '0;
    endtask

    task automatic request(input logic we, input logic [PADDR_BITS-1:0] a,
                           input logic [LW-1:0] d, input int stall, input bit inject);
        bit   ok;
        int   n;
        int   i;
        exp_t e;
        i = idx_of(a);
        accept(we, a, d, ok);
        if (!ok) return;
        e.addr = a & ALIGN;
        e.line = we ? d : (m_wr[i] ? m_mem[i] : '0);
        sb.push_back(e);
        if (we) begin
            m_mem[i] = d;
            m_wr[i]  = 1'b1;
        end
        check("busy_ready", hc_ready_out, 0);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (hc_valid_out) break;
        end
        if (!hc_valid_out) begin
            check("resp_timeout", 0, 1);
            return;
        end
        check("latency", n, LATENCY);
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("resp_addr", hc_addr_out, e.addr);
        check("resp_line", hc_line_out, e.line);
        check("resp_ready", hc_ready_out, 0);
        for (int k = 0; k < stall; k++) begin
            if (inject && k == 0) begin
                // Should be ignored: the responder is not ready.
                hc_valid_in = 1'b1;
                hc_we_in    = 1'b1;
                hc_addr_in  = 19'h00200;
                hc_line_in  = {LW{1'b1}};
            end
            @(negedge clk);
            check("stall_valid", hc_valid_out, 1);
            check("stall_addr", hc_addr_out, e.addr);
            check("stall_line", hc_line_out, e.line);
            check("stall_ready", hc_ready_out, 0);
        end
        hc_ready_in = 1'b1;
        @(posedge clk);
        if (we) m_wr_cnt++;
        else    m_rd_cnt++;
        @(negedge clk);
        hc_ready_in = 1'b0;
        hc_valid_in = 1'b0;
        hc_we_in    = 1'b0;
        hc_line_in  = '0;
        check("handoff_valid", hc_valid_out, 0);
        check("handoff_ready", hc_ready_out, 0);
        @(negedge clk);
        check("ready_back", hc_ready_out, 1);
    endtask

    initial begin
        bit               ok;
        int               bad;
        logic [LW-1:0]    d;
        logic [PADDR_BITS-1:0] a;

        for (int i = 0; i < LINES; i++) m_wr[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", hc_ready_out, 0);
        check("rst_valid", hc_valid_out, 0);
        check("rst_addr", hc_addr_out, 0);
        check("rst_line", hc_line_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", hc_ready_out, 1);

        // First fill from a never-written line returns zeros.
        request(1'b0, 19'h00040, '0, 0, 1'b0);

        // Writeback then fill at an unaligned address in the same line.
        request(1'b1, 19'h00080, {B{8'hA5}}, 0, 1'b0);
        request(1'b0, 19'h000BF, '0, 0, 1'b0);

        // Long RESP stall, with a request presented while busy.
        request(1'b0, 19'h00080, '0, 10, 1'b1);
        request(1'b0, 19'h00200, '0, 0, 1'b0);

        // Aliasing through high address bits.
        request(1'b1, 19'h00100, rand_line(), 0, 1'b0);
        request(1'b0, 19'h01100, '0, 0, 1'b0);

        // Random write/read-back pairs through aliased addresses.
        for (int r = 0; r < 4; r++) begin
            a = PADDR_BITS'($urandom);
            d = rand_line();
            request(1'b1, a, d, $urandom_range(0, 3), 1'b0);
            a = a ^ (PADDR_BITS'($urandom_range(1, 63)) << (OFF_W + $clog2(LINES)));
            request(1'b0, a, '0, 0, 1'b0);
        end

        // Reset while a write is in WAIT: the write must be lost.
        accept(1'b1, 19'h00140, {B{8'h3C}}, ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", hc_valid_out, 0);
        check("midrst_ready", hc_ready_out, 0);
        rst = 1'b0;
        for (int i = 0; i < LINES; i++) m_wr[i] = 1'b0;
        m_rd_cnt = 0;
        m_wr_cnt = 0;
        bad = 0;
        for (int k = 0; k < LATENCY + 4; k++) begin
            @(negedge clk);
            if (hc_valid_out !== 1'b0) bad++;
        end
        check("no_stale_valid", bad, 0);
        request(1'b0, 19'h00140, '0, 0, 1'b0);
        request(1'b0, 19'h00080, '0, 0, 1'b0);
        request(1'b1, 19'h00180, rand_line(), 0, 1'b0);
        request(1'b0, 19'h00180, '0, 1, 1'b0);
        request(1'b1, 19'h001C0, rand_line(), 2, 1'b0);

`ifdef LC_RESPONDER_STATS_EN
        check("rd_count", rd_count_out, m_rd_cnt);
        check("wr_count", wr_count_out, m_wr_cnt);
`endif
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lc_line_responder.md
LC_LINE_RESPONDER -- requirements
Module: lc_line_responder

Interface
REQ-001 The module SHALL have parameter B, default 64, cache line size in bytes (power of two).
REQ-002 The module SHALL have parameter PADDR_BITS, default 19, physical address width.
REQ-003 The module SHALL have parameter LINES, default 64, number of backing lines (power of two).
REQ-004 The module SHALL have parameter LATENCY, default 4, request-accept to response-valid delay in cycles (minimum 1).
REQ-005 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Port clk_in  in  1  clock; all state changes on the rising edge.
REQ-007 Port rst_in  in  1  asynchronous active-high reset.
REQ-008 Port hc_valid_in  in  1  requester (L1D) presents a request.
REQ-009 Port hc_addr_in  in  PADDR_BITS  request byte address.
REQ-010 Port hc_we_in  in  1  1 = line writeback, 0 = line fill.
REQ-011 Port hc_line_in  in  8*B  writeback line data.
REQ-012 Port hc_ready_in  in  1  requester accepts the response.
REQ-013 Port hc_ready_out  out  1  responder accepts a request.
REQ-014 Port hc_valid_out  out  1  response valid.
REQ-015 Port hc_addr_out  out  PADDR_BITS  line-aligned address of the response.
REQ-016 Port hc_line_out  out  8*B  response line data.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-018 hc_ready_out SHALL be 1 only in IDLE.
REQ-019 A request is accepted on a rising edge with hc_valid_in=1 and hc_ready_out=1; on acceptance: latch address with low log2(B) bits forced to 0, latch we and line, load the counter with LATENCY-1, go to WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle; at counter=0, enter RESP on the next edge.
REQ-021 hc_valid_out SHALL be 1 only in RESP; it SHALL first assert exactly LATENCY cycles after the acceptance edge.
REQ-022 Line index SHALL be addr[log2(B)+log2(LINES)-1 : log2(B)]; higher address bits alias.
REQ-023 Writes SHALL update the backing line and set its written bit at the WAIT->RESP edge; hc_line_out SHALL equal the written data.
REQ-024 Reads SHALL return the stored line if its written bit is set, else all zeros.
REQ-025 hc_valid_out, hc_addr_out and hc_line_out SHALL hold stable in RESP until hc_ready_in=1 on an edge; then return to IDLE.
REQ-026 hc_ready_out SHALL be 0 in the RESP-to-IDLE handoff cycle: back-to-back requests SHALL see at least one idle cycle between response completion and the next accept.
REQ-027 Requests with hc_valid_in=1 while hc_ready_out=0 SHALL be ignored without side effects.
REQ-028 A read following a write to the same index SHALL return the written data.

Reset
REQ-029 While rst_in=1: state IDLE, counter 0, hc_ready_out=0, hc_valid_out=0, hc_addr_out=0, hc_line_out=0, all written bits 0.
REQ-030 hc_ready_out SHALL rise on the first edge after rst_in deasserts.
REQ-031 Reset mid-operation SHALL discard the in-flight request, including an un-committed write.
REQ-032 Backing line data SHALL NOT be reset; written bits alone define visibility.

Configuration
REQ-033 With macro LC_RESPONDER_STATS_EN defined, the module SHALL add outputs rd_count_out and wr_count_out (16 bits each), which increment per completed read/write response handshake, saturate at 0xFFFF, and reset to 0.
REQ-034 Without LC_RESPONDER_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Reset, then read 0x00040 -> hc_valid_out after 4 cycles, hc_addr_out=0x00040, hc_line_out=0.
REQ-036 Write 0x00080 with line all-0xA5, then read 0x000BF -> read response line all-0xA5, hc_addr_out=0x00080.
REQ-037 Hold hc_ready_in=0 for 10 cycles in RESP -> outputs stable and hc_ready_out=0 throughout; completion once hc_ready_in=1.
REQ-038 Write 0x00100, then read 0x01100 (LINES=64 alias) -> the written data is returned.
REQ-039 Assert rst_in during WAIT of a write to 0x00140, then read 0x00140 -> zeros, and no stale hc_valid_out.
REQ-040 With LC_RESPONDER_STATS_EN defined, complete 3 reads and 2 writes -> rd_count_out=3, wr_count_out=2.
